// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths and the writeback request type for the CPU slice.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/ldq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ldq_fifo
// Brief    : In-order queue of pending load returns (power-of-two depth).
// Revision : 1.0 - initial release
// ============================================================================
module ldq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_req_t          push_data_i,
  input  logic             pop_i,
  output wb_req_t          head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int               PTR_W   = CNT_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Caller never pushes when full nor pops when empty.
  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!push_i && pop_i) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Brief    : Merges ALU results and queued load returns onto the register-file
//            write port; keeps the pending-load scoreboard. Macro WB_FWD_EN
//            enables the forwarding copy and same-cycle scoreboard clear.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
  import cpu_pkg::*;
#(
  parameter int LDQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue_valid,
  input  logic [ADDR_W-1:0] ld_issue_rd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREGS-1:0]  busy,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int CNT_W = $clog2(LDQ_DEPTH) + 1;

  wb_req_t           q_head;
  wb_req_t           ld_req;
  wb_req_t           wr_req;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic              ld_acc;
  logic              q_pop;
  logic              q_push;
  logic              direct;
  logic              wr_en;
  logic [ADDR_W-1:0] clr_rd;
  logic [NREGS-1:0]  set_vec;
  logic [NREGS-1:0]  clr_vec;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // Held low through reset so upstream cannot hand over data that reset would drop.
  assign ld_ready = rst_n && (q_count != CNT_W'(LDQ_DEPTH));
  assign ld_acc   = ld_valid && ld_ready;
  assign ld_req   = '{rd: ld_rd, data: ld_data};

  // ALU first, then the queue head, then a bypassing load only when nothing is queued.
  assign q_pop  = !alu_valid && !q_empty;
  assign direct = !alu_valid && q_empty && ld_acc;
  assign q_push = ld_acc && !direct && !q_full;
  assign wr_en  = alu_valid || !q_empty || ld_acc;
  assign clr_rd = q_empty ? ld_rd : q_head.rd;

  always_comb begin
    wr_req = ld_req;
    if (alu_valid) begin
      wr_req = '{rd: alu_rd, data: alu_data};
    end else if (!q_empty) begin
      wr_req = q_head;
    end
  end

  ldq_fifo #(
    .DEPTH (LDQ_DEPTH),
    .CNT_W (CNT_W)
  ) u_ldq (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (q_push),
    .push_data_i (ld_req),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      set_vec[i] = ld_issue_valid && (ld_issue_rd == ADDR_W'(i));
      clr_vec[i] = (q_pop || direct) && (clr_rd == ADDR_W'(i));
    end
  end

`ifdef WB_FWD_EN
  assign busy_d = (busy_q & ~clr_vec) | set_vec;

  assign fwd_valid = rf_we_q;
  assign fwd_addr  = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;
`else
  // Clear lands one cycle after the write so decode reads the committed value;
  // a re-issue in either cycle keeps the bit set.
  logic [NREGS-1:0] clr_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_dly_q <= '0;
    else        clr_dly_q <= clr_vec & ~set_vec;
  end

  assign busy_d = (busy_q & ~clr_dly_q) | set_vec;

  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q <= wr_en;
      if (wr_en) begin
        rf_waddr_q <= wr_req.rd;
        rf_wdata_q <= wr_req.data;
      end
      busy_q <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Writeback stage between execute/memory and the 16-entry register file write port. Merges single-cycle ALU results with variable-latency load returns onto the one register-file write port. ALU results always win. Load returns wait in a small in-order queue until the port is free. A per-register pending-load scoreboard is exported to decode for stall generation.

## Interface
- `DATA_W`, 32, register data width
- `ADDR_W`, 4, register address width
- `NREGS`, 16, number of architectural registers (2**ADDR_W)
- `LDQ_DEPTH`, 4, load-return queue entries (power of two, ≥2)

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `ld_issue_valid`  in  1  load issued to memory this cycle
- `ld_issue_rd`  in  ADDR_W  destination of issued load
- `ld_valid`  in  1  load data returning
- `ld_ready`  out  1  queue can accept a load return
- `ld_rd`  in  ADDR_W  returning load destination
- `ld_data`  in  DATA_W  returning load data
- `rf_we`  out  1  register-file write enable, registered
- `rf_waddr`  out  ADDR_W  register-file write address, registered
- `rf_wdata`  out  DATA_W  register-file write data, registered
- `busy`  out  NREGS  pending-load scoreboard, bit i = load to Ri outstanding
- `fwd_valid`, `fwd_addr`, `fwd_data`  out  1/ADDR_W/DATA_W  forwarding copy of the write port (see Configuration)

## Operation
- Load return is accepted on `ld_valid && ld_ready`.
- `ld_ready = !full`, combinational from queue count. There is no same-cycle pass-through when the queue is full.
- Write-port selection, evaluated each cycle:
  - `alu_valid`: write the ALU result.
  - else queue non-empty: write the queue head and pop it.
  - else an accepted load this cycle: write it directly, bypassing the queue.
  - else `rf_we` = 0.
- An accepted load not written that cycle is pushed to the queue tail.
- Loads write back in acceptance order.
- Scoreboard:
  - `ld_issue_valid` sets `busy[ld_issue_rd]`.
  - Writing a load result clears `busy[rd]`.
  - If set and clear hit the same register in the same cycle, set wins.
  - ALU writes never affect `busy`.
- Upstream guarantees:
  - Decode stalls any instruction whose source or destination has its `busy` bit set, so an ALU write never targets a busy register.
  - No load is issued to an already-busy register.
  - The bench asserts both rules.

## Timing
- Reset (async assert, sync release):
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `busy`=0, queue empty.
  - `ld_ready`=0 while `rst_n` low, 1 from the first cycle after release.
  - `fwd_*`=0.
- Reset mid-operation discards queued loads and clears the scoreboard.
- ALU latency: result on `rf_*` in the cycle after `alu_valid`.
- Load latency:
  - 1 cycle when the queue is empty and `alu_valid`=0.
  - Otherwise 1 cycle + queue occupancy + intervening ALU cycles.
- Starvation: under continuous `alu_valid` the queue fills and `ld_ready` drops. This is acceptable because the pipeline cannot sustain that pattern.
- Queue full with push and pop in the same cycle: not possible, since `ld_ready`=0 when full.
- Pointers wrap modulo `LDQ_DEPTH`. Count is ADDR of log2(`LDQ_DEPTH`)+1 bits.
- `busy[rd]` clears in the same cycle `rf_we` asserts for that load.

## Configuration
- `WB_FWD_EN` defined:
  - `fwd_valid`/`fwd_addr`/`fwd_data` mirror `rf_we`/`rf_waddr`/`rf_wdata`.
  - Decode may consume a register whose `busy` bit clears this cycle by forwarding.
- `WB_FWD_EN` undefined:
  - `fwd_*` tied to 0.
  - `busy[rd]` clears one cycle after the write, so decode reads the updated register-file value.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`, `ADDR_W`, `NREGS`.
  - Typedef `wb_req_t` {rd, data}.
- Sub-module `ldq_fifo`: parameterised synchronous FIFO of `wb_req_t` with push/pop/full/empty/count.
- `wb_stage` holds the arbitration, output registers and scoreboard.

## Test plan
- Reset, then `alu_valid`=1, rd=3, data=0x0000_0002 → next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=2; `busy`=0.
- `ld_issue` rd=11; 3 cycles later `ld_valid` rd=11, data=5, no ALU → `busy[11]`=1 until the write cycle; `rf_wdata`=5 one cycle after accept.
- Load rd=4 data=0xAA and ALU rd=2 data=0x55 in the same cycle → ALU written first, load written the following cycle; order holds.
- Hold `alu_valid`=1 for 6 cycles while offering 5 loads → `ld_ready`=0 after 4 accepts; the loads then drain in order 1 per cycle once ALU stops.
- Same-cycle `ld_issue` rd=7 and writeback of a load to rd=7 → `busy[7]` stays 1.
- Assert `rst_n`=0 with 2 loads queued → all outputs 0 immediately; after release the queue is empty and no stale write appears. Repeat with and without `WB_FWD_EN`, checking `busy` clear timing.
